// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the hazard controller and the pipeline datapath.
// slave = controller side, master = pipeline/driver side.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W  = 5,
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
);
    logic [REG_W-1:0]  id_rs1;
    logic [REG_W-1:0]  id_rs2;
    logic              id_rs1_use;
    logic              id_rs2_use;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_is_load;
    logic              ex_multi_start;
    logic [CNT_W-1:0]  ex_multi_lat;
    logic              ex_redirect;
    logic              mem_req_valid;
    logic              mem_ready;

    logic              pc_en;
    logic              ifid_en;
    logic              ifid_clr;
    logic              idex_en;
    logic              idex_clr;
    logic              exmem_en;
    logic              exmem_clr;
    logic              memwb_en;
    logic              memwb_clr;
    logic              multi_busy;
    logic [PERF_W-1:0] perf_stall;
    logic [PERF_W-1:0] perf_flush;

    modport slave (
        input  id_rs1, id_rs2, id_rs1_use, id_rs2_use,
        input  ex_rd, ex_is_load, ex_multi_start, ex_multi_lat,
        input  ex_redirect, mem_req_valid, mem_ready,
        output pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
        output exmem_en, exmem_clr, memwb_en, memwb_clr,
        output multi_busy, perf_stall, perf_flush
    );

    modport master (
        output id_rs1, id_rs2, id_rs1_use, id_rs2_use,
        output ex_rd, ex_is_load, ex_multi_start, ex_multi_lat,
        output ex_redirect, mem_req_valid, mem_ready,
        input  pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
        input  exmem_en, exmem_clr, memwb_en, memwb_clr,
        input  multi_busy, perf_stall, perf_flush
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use, redirect, multi-cycle EX, mem wait.
// Optional stall/flush performance counters enabled by PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int REG_W  = 5,
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic               clk,
    input  logic               rstn,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_MULTI = 1'b1;

    logic [0:0]       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic memwait;
    logic in_multi;
    logic cnt_zero;
    logic lu_hit;
    logic start_ok;
    logic redir_act;

    logic pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
    logic exmem_en, exmem_clr, memwb_en, memwb_clr;

    assign memwait  = bus.mem_req_valid & ~bus.mem_ready;
    assign in_multi = (st_q == ST_MULTI);
    assign cnt_zero = (cnt_q == '0);
    assign start_ok = bus.ex_multi_start &
                      (bus.ex_multi_lat >= CNT_W'(2));

    assign lu_hit = bus.ex_is_load & (bus.ex_rd != '0) &
                    ((bus.id_rs1_use & (bus.id_rs1 == bus.ex_rd)) |
                     (bus.id_rs2_use & (bus.id_rs2 == bus.ex_rd)));

    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        redir_act = 1'b0;
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        ifid_clr  = 1'b0;
        idex_en   = 1'b1;
        idex_clr  = 1'b0;
        exmem_en  = 1'b1;
        exmem_clr = 1'b0;
        memwb_en  = 1'b1;
        memwb_clr = 1'b0;

        if (!rstn) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            ifid_clr  = 1'b1;
            idex_en   = 1'b0;
            idex_clr  = 1'b1;
            exmem_en  = 1'b0;
            exmem_clr = 1'b1;
            memwb_en  = 1'b0;
            memwb_clr = 1'b1;
        end else begin
            // The multi-cycle op keeps counting even while memory stalls.
            if (in_multi && !cnt_zero)
                cnt_d = cnt_q - CNT_W'(1);

            if (memwait) begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                idex_en   = 1'b0;
                exmem_en  = 1'b0;
                memwb_clr = 1'b1;
            end else if (in_multi && !cnt_zero) begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                idex_en   = 1'b0;
                exmem_clr = 1'b1;
            end else if (!in_multi && start_ok) begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                idex_en   = 1'b0;
                exmem_clr = 1'b1;
                st_d      = ST_MULTI;
                cnt_d     = bus.ex_multi_lat - CNT_W'(2);
            end else begin
                if (in_multi)
                    st_d = ST_RUN;
                if (bus.ex_redirect) begin
                    redir_act = 1'b1;
                    ifid_clr  = 1'b1;
                    idex_clr  = 1'b1;
                end else if (lu_hit) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_clr = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st_q  <= ST_RUN;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.pc_en      = pc_en;
    assign bus.ifid_en    = ifid_en;
    assign bus.ifid_clr   = ifid_clr;
    assign bus.idex_en    = idex_en;
    assign bus.idex_clr   = idex_clr;
    assign bus.exmem_en   = exmem_en;
    assign bus.exmem_clr  = exmem_clr;
    assign bus.memwb_en   = memwb_en;
    assign bus.memwb_clr  = memwb_clr;
    assign bus.multi_busy = in_multi;

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (!pc_en && perf_stall_q != '1)
            perf_stall_d = perf_stall_q + PERF_W'(1);
        if (redir_act && perf_flush_q != '1)
            perf_flush_d = perf_flush_q + PERF_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign bus.perf_stall = perf_stall_q;
    assign bus.perf_flush = perf_flush_q;
`else
    assign bus.perf_stall = '0;
    assign bus.perf_flush = '0;
`endif

`ifndef SYNTHESIS
    a_no_start_with_redirect : assert property (
        @(posedge clk) disable iff (!rstn)
        !(bus.ex_multi_start && bus.ex_redirect)
    );
`endif
endmodule
